i2s_clk_sched: RTL and testbench
================================

Name: i2s_clk_sched

Overview:
- Runtime-reconfigurable I2S clock scheduler. Generates lrclk/sclk from the master clock with programmable half-period dividers.
- Owns the full sequence for a sample-rate change: validate the request, finish the current frame, hold a quiet gap, reload the dividers, then restart frame-aligned.
- Sits between the audio config register block and the I2S TX/RX serializers. Downstream blocks align to frame_start.

Parameters:
- LRCLK_DIV_W, 16: width of the lrclk half-period divider.
- SCLK_DIV_W, 8: width of the sclk half-period divider.
- DEFAULT_LRCLK_DIV, 384: lrclk half-period in clk cycles after reset.
- DEFAULT_SCLK_DIV, 8: sclk half-period in clk cycles after reset.
- QUIET_CYCLES, 16: idle gap in clk cycles between stop and restart on reconfig. Must be 1 or more.
- LRCLK_INIT, 0: lrclk level when idle or reset.
- SCLK_INIT, 0: sclk level when idle or reset.

Ports:
- clk  in  1  master clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request. Level-sensitive.
- cfg_valid  in  1  reconfig request valid.
- cfg_ready  out  1  reconfig request accepted when cfg_valid and cfg_ready are both high.
- cfg_lrclk_div  in  LRCLK_DIV_W  requested lrclk half-period.
- cfg_sclk_div  in  SCLK_DIV_W  requested sclk half-period.
- cfg_err  out  1  one-cycle pulse: request rejected.
- cfg_done  out  1  one-cycle pulse: new dividers loaded.
- lrclk  out  1  word clock.
- sclk  out  1  bit clock.
- running  out  1  clocks are toggling.
- frame_start  out  1  one-cycle pulse marking the first clk cycle of each frame.

Behaviour:
- Reset values:
  - State IDLE.
  - Active dividers = DEFAULT_LRCLK_DIV and DEFAULT_SCLK_DIV.
  - Counters 0; pending request discarded.
  - lrclk = LRCLK_INIT, sclk = SCLK_INIT.
  - running, frame_start, cfg_err and cfg_done all 0; cfg_ready = 1.
  - Reset in any state, including mid-DRAIN or mid-CHECK, returns to these values in the next cycle.
- Divider rule: each counter runs 0 to div-1. At div-1 the counter wraps to 0 and its clock inverts, giving a period of 2*div cycles.
- States: IDLE, RUN, CHECK, DRAIN, QUIET.
- IDLE:
  - Clocks held at INIT levels, counters 0.
  - enable=1 → RUN next cycle. frame_start pulses in the first RUN cycle.
  - The first toggle occurs div cycles after entering RUN.
- RUN:
  - Counters advance; running=1.
  - frame_start pulses on the cycle after lrclk returns to LRCLK_INIT.
  - enable=0 → DRAIN with the stop flag set.
- Handshake:
  - cfg_ready=1 only in IDLE and RUN.
  - On acceptance, capture both dividers into pending registers, record the origin state, and enter CHECK.
  - When enable falls in the same cycle as an accept, the accept takes priority. The stop is taken after reconfig completes if enable is still 0.
- CHECK (validation; clocks keep running if entered from RUN):
  - Reject immediately if either divider is 0.
  - Otherwise set rem = lrclk_div, then evaluate once per cycle:
    - rem==0 → valid.
    - rem < sclk_div → invalid.
    - else rem -= sclk_div.
  - Latency is lrclk_div/sclk_div + 1 cycles; the bound is 2^LRCLK_DIV_W cycles.
  - Invalid: cfg_err pulses, return to the origin state, active dividers unchanged, no glitch on the clocks.
  - Valid from IDLE: load the dividers, pulse cfg_done, return to IDLE.
  - Valid from RUN: go to DRAIN.
- DRAIN:
  - Run until the frame end, defined as the cycle where lrclk != LRCLK_INIT and lrclk_ctr == div-1.
  - In that cycle, force lrclk and sclk to INIT, clear the counters, and go to QUIET. running drops the next cycle.
  - No truncated half-periods are allowed on either clock.
  - If the stop flag is set and no reconfig is pending, go directly to IDLE instead of QUIET.
- QUIET:
  - Hold INIT levels for exactly QUIET_CYCLES cycles.
  - Then load the pending dividers and pulse cfg_done.
  - Next state is RUN if enable=1 (with frame_start pulse), else IDLE.
- cfg_valid in CHECK, DRAIN or QUIET is not accepted; the requester holds it.

Test Plan:
- Reset, enable=1 with defaults → first lrclk toggle 384 cycles after entering RUN; period 768 cycles; sclk period 16 cycles; frame_start every 768 cycles.
- Mid-frame request 256/4 → cfg_ready drops, the current frame completes with full half-periods, 16 quiet cycles at INIT, cfg_done pulses, then lrclk period 512 and sclk period 8.
- Request 100/8 while running → cfg_err pulses after 14 cycles (rem 100→4 over 12 subtractions, 4<8 rejects); clocks are undisturbed and the divider stays 384.
- Requests 0/8 and 384/0 → cfg_err the cycle after entering CHECK; no state change.
- enable deasserted mid-frame → clocks continue to the frame end, then IDLE at INIT levels; running=0; no QUIET gap.
- rst asserted during DRAIN after a 256/4 request → next cycle IDLE, dividers 384/8; a subsequent enable runs at the default rate.

Source files
------------

// File: rtl/i2s_clk_sched.sv
// i2s_clk_sched: runtime-reconfigurable I2S clock scheduler.
// Derives lrclk/sclk from clk using programmable half-period dividers. It also
// sequences a sample-rate change: validate, finish the frame, quiet gap,
// reload, then restart frame-aligned.
//
// Ports:
//   clk, rst          master clock, synchronous active-high reset
//   enable            level-sensitive run request
//   cfg_valid/ready   reconfig handshake (ready only in IDLE and RUN)
//   cfg_lrclk_div     requested lrclk half-period (clk cycles)
//   cfg_sclk_div      requested sclk half-period (clk cycles)
//   cfg_err           one-cycle pulse: request rejected
//   cfg_done          one-cycle pulse: new dividers loaded
//   lrclk, sclk       word / bit clocks
//   running           clocks are toggling
//   frame_start       one-cycle pulse on the first clk cycle of each frame
module i2s_clk_sched #(
  parameter int unsigned LRCLK_DIV_W       = 16,
  parameter int unsigned SCLK_DIV_W        = 8,
  parameter int unsigned DEFAULT_LRCLK_DIV = 384,
  parameter int unsigned DEFAULT_SCLK_DIV  = 8,
  parameter int unsigned QUIET_CYCLES      = 16,
  parameter logic        LRCLK_INIT        = 1'b0,
  parameter logic        SCLK_INIT         = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [LRCLK_DIV_W-1:0] cfg_lrclk_div,
  input  logic [SCLK_DIV_W-1:0]  cfg_sclk_div,
  output logic                   cfg_err,
  output logic                   cfg_done,
  output logic                   lrclk,
  output logic                   sclk,
  output logic                   running,
  output logic                   frame_start
);

  localparam int unsigned QUIET_W = $clog2(QUIET_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_DRAIN,
    ST_QUIET
  } state_t;

  state_t                 state;
  logic [LRCLK_DIV_W-1:0] lr_div;
  logic [SCLK_DIV_W-1:0]  sc_div;
  logic [LRCLK_DIV_W-1:0] lr_ctr;
  logic [SCLK_DIV_W-1:0]  sc_ctr;
  logic [LRCLK_DIV_W-1:0] pend_lr;
  logic [SCLK_DIV_W-1:0]  pend_sc;
  logic [LRCLK_DIV_W-1:0] rem;
  logic                   from_run;
  logic                   stop;
  logic                   pend;
  logic [QUIET_W-1:0]     quiet_ctr;

  // Divider wrap points and next counter/clock values for one advance step.
  logic                   lr_wrap_c;
  logic                   sc_wrap_c;
  logic                   frame_end_c;
  logic                   accept_c;
  logic [LRCLK_DIV_W-1:0] lr_ctr_nxt_c;
  logic [SCLK_DIV_W-1:0]  sc_ctr_nxt_c;
  logic                   lrclk_nxt_c;
  logic                   sclk_nxt_c;
  logic [LRCLK_DIV_W-1:0] pend_sc_ext_c;
  logic                   pend_zero_c;

  always_comb begin
    lr_wrap_c     = (lr_ctr == lr_div - LRCLK_DIV_W'(1));
    sc_wrap_c     = (sc_ctr == sc_div - SCLK_DIV_W'(1));
    // Frame end: last cycle of the non-INIT lrclk half.
    frame_end_c   = lr_wrap_c && (lrclk != LRCLK_INIT);
    accept_c      = cfg_valid && cfg_ready;
    lr_ctr_nxt_c  = lr_wrap_c ? '0 : lr_ctr + LRCLK_DIV_W'(1);
    sc_ctr_nxt_c  = sc_wrap_c ? '0 : sc_ctr + SCLK_DIV_W'(1);
    lrclk_nxt_c   = lr_wrap_c ? ~lrclk : lrclk;
    sclk_nxt_c    = sc_wrap_c ? ~sclk : sclk;
    pend_sc_ext_c = LRCLK_DIV_W'(pend_sc);
    pend_zero_c   = (pend_lr == '0) || (pend_sc == '0);
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lr_div      <= LRCLK_DIV_W'(DEFAULT_LRCLK_DIV);
      sc_div      <= SCLK_DIV_W'(DEFAULT_SCLK_DIV);
      lr_ctr      <= '0;
      sc_ctr      <= '0;
      pend_lr     <= '0;
      pend_sc     <= '0;
      rem         <= '0;
      from_run    <= 1'b0;
      stop        <= 1'b0;
      pend        <= 1'b0;
      quiet_ctr   <= '0;
      lrclk       <= LRCLK_INIT;
      sclk        <= SCLK_INIT;
      running     <= 1'b0;
      frame_start <= 1'b0;
      cfg_err     <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_ready   <= 1'b1;
    end else begin
      cfg_err     <= 1'b0;
      cfg_done    <= 1'b0;
      frame_start <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            pend_lr   <= cfg_lrclk_div;
            pend_sc   <= cfg_sclk_div;
            rem       <= cfg_lrclk_div;
            from_run  <= 1'b0;
            cfg_ready <= 1'b0;
            state     <= ST_CHECK;
          end else if (enable) begin
            running     <= 1'b1;
            frame_start <= 1'b1;
            state       <= ST_RUN;
          end
        end

        ST_RUN: begin
          lr_ctr      <= lr_ctr_nxt_c;
          sc_ctr      <= sc_ctr_nxt_c;
          lrclk       <= lrclk_nxt_c;
          sclk        <= sclk_nxt_c;
          frame_start <= frame_end_c;
          // A reconfig accept wins over a simultaneous enable drop.
          if (accept_c) begin
            pend_lr   <= cfg_lrclk_div;
            pend_sc   <= cfg_sclk_div;
            rem       <= cfg_lrclk_div;
            from_run  <= 1'b1;
            cfg_ready <= 1'b0;
            state     <= ST_CHECK;
          end else if (!enable) begin
            stop      <= 1'b1;
            pend      <= 1'b0;
            cfg_ready <= 1'b0;
            state     <= ST_DRAIN;
          end
        end

        ST_CHECK: begin
          if (from_run) begin
            lr_ctr      <= lr_ctr_nxt_c;
            sc_ctr      <= sc_ctr_nxt_c;
            lrclk       <= lrclk_nxt_c;
            sclk        <= sclk_nxt_c;
            frame_start <= frame_end_c;
          end
          // Iterative divisibility test: lrclk_div must be a multiple of sclk_div.
          if (pend_zero_c || ((rem != '0) && (rem < pend_sc_ext_c))) begin
            cfg_err   <= 1'b1;
            cfg_ready <= 1'b1;
            state     <= from_run ? ST_RUN : ST_IDLE;
          end else if (rem == '0) begin
            if (from_run) begin
              pend  <= 1'b1;
              stop  <= 1'b0;
              state <= ST_DRAIN;
            end else begin
              lr_div    <= pend_lr;
              sc_div    <= pend_sc;
              cfg_done  <= 1'b1;
              cfg_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end else begin
            rem <= rem - pend_sc_ext_c;
          end
        end

        ST_DRAIN: begin
          if (frame_end_c) begin
            // Both clocks are at the end of a full half-period here.
            lr_ctr  <= '0;
            sc_ctr  <= '0;
            lrclk   <= LRCLK_INIT;
            sclk    <= SCLK_INIT;
            running <= 1'b0;
            if (stop && !pend) begin
              stop      <= 1'b0;
              cfg_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              quiet_ctr <= '0;
              state     <= ST_QUIET;
            end
          end else begin
            lr_ctr <= lr_ctr_nxt_c;
            sc_ctr <= sc_ctr_nxt_c;
            lrclk  <= lrclk_nxt_c;
            sclk   <= sclk_nxt_c;
          end
        end

        ST_QUIET: begin
          if (quiet_ctr == QUIET_W'(QUIET_CYCLES - 1)) begin
            lr_div    <= pend_lr;
            sc_div    <= pend_sc;
            cfg_done  <= 1'b1;
            cfg_ready <= 1'b1;
            pend      <= 1'b0;
            stop      <= 1'b0;
            if (enable) begin
              running     <= 1'b1;
              frame_start <= 1'b1;
              state       <= ST_RUN;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            quiet_ctr <= quiet_ctr + QUIET_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_clk_sched.sv
// Directed bench for i2s_clk_sched: default rate, rejected requests,
// mid-run reconfig, disable drain, reset during drain and reconfig from idle.
module tb_i2s_clk_sched;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_lrclk_div;
  logic [7:0]  cfg_sclk_div;
  logic        cfg_err;
  logic        cfg_done;
  logic        lrclk;
  logic        sclk;
  logic        running;
  logic        frame_start;

  int checks;
  int errors;

  i2s_clk_sched dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_lrclk_div (cfg_lrclk_div),
    .cfg_sclk_div  (cfg_sclk_div),
    .cfg_err       (cfg_err),
    .cfg_done      (cfg_done),
    .lrclk         (lrclk),
    .sclk          (sclk),
    .running       (running),
    .frame_start   (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  // Advance n cycles; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_lrclk_div = '0; cfg_sclk_div = '0;
    step(3);
    checks++;
    if ({lrclk, sclk, running, frame_start, cfg_err, cfg_done, cfg_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_state: got %b want %b",
               {lrclk, sclk, running, frame_start, cfg_err, cfg_done, cfg_ready}, 7'b0000001);
    end
    rst = 1'b0;
    step(2);
  endtask

  // Leaves the bench at k=0 of a frame (frame_start observed).
  task automatic test_default_run;
    enable = 1'b1;
    step(1);
    checks++;
    if ({running, frame_start, lrclk} !== 3'b110) begin
      errors++;
      $display("FAIL run_first_cycle: got %b want %b", {running, frame_start, lrclk}, 3'b110);
    end
    step(7);
    checks++;
    if (sclk !== 1'b0) begin errors++; $display("FAIL sclk_k7: got %b want 0", sclk); end
    step(1);
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL sclk_k8: got %b want 1", sclk); end
    step(8);
    checks++;
    if (sclk !== 1'b0) begin errors++; $display("FAIL sclk_k16: got %b want 0", sclk); end
    step(367);
    checks++;
    if (lrclk !== 1'b0) begin errors++; $display("FAIL lrclk_k383: got %b want 0", lrclk); end
    step(1);
    checks++;
    if (lrclk !== 1'b1) begin errors++; $display("FAIL lrclk_k384: got %b want 1", lrclk); end
    step(383);
    checks++;
    if ({lrclk, frame_start} !== 2'b10) begin
      errors++; $display("FAIL frame_k767: got %b want %b", {lrclk, frame_start}, 2'b10);
    end
    step(1);
    checks++;
    if ({lrclk, frame_start} !== 2'b01) begin
      errors++; $display("FAIL frame_k768: got %b want %b", {lrclk, frame_start}, 2'b01);
    end
  endtask

  task automatic test_reject_range;
    cfg_valid = 1'b1; cfg_lrclk_div = 16'd100; cfg_sclk_div = 8'd8;
    step(1);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL r100_ready_k1: got %b want 0", cfg_ready); end
    step(12);
    checks++;
    if ({cfg_err, cfg_ready} !== 2'b00) begin
      errors++; $display("FAIL r100_k13: got %b want %b", {cfg_err, cfg_ready}, 2'b00);
    end
    step(1);
    checks++;
    if ({cfg_err, cfg_ready, cfg_done} !== 3'b110) begin
      errors++; $display("FAIL r100_err_k14: got %b want %b", {cfg_err, cfg_ready, cfg_done}, 3'b110);
    end
    step(1);
    checks++;
    if (cfg_err !== 1'b0) begin errors++; $display("FAIL r100_pulse_k15: got %b want 0", cfg_err); end
    step(368);
    checks++;
    if (lrclk !== 1'b0) begin errors++; $display("FAIL r100_lrclk_k383: got %b want 0", lrclk); end
    step(1);
    checks++;
    if (lrclk !== 1'b1) begin errors++; $display("FAIL r100_lrclk_k384: got %b want 1", lrclk); end
    step(384);
    checks++;
    if ({lrclk, frame_start} !== 2'b01) begin
      errors++; $display("FAIL r100_frame_k768: got %b want %b", {lrclk, frame_start}, 2'b01);
    end
  endtask

  task automatic test_reject_zero;
    cfg_valid = 1'b1; cfg_lrclk_div = 16'd0; cfg_sclk_div = 8'd8;
    step(1);
    checks++;
    if ({cfg_err, cfg_ready} !== 2'b00) begin
      errors++; $display("FAIL z0_k1: got %b want %b", {cfg_err, cfg_ready}, 2'b00);
    end
    cfg_lrclk_div = 16'd384; cfg_sclk_div = 8'd0;
    step(1);
    checks++;
    if ({cfg_err, cfg_ready} !== 2'b11) begin
      errors++; $display("FAIL z0_err_k2: got %b want %b", {cfg_err, cfg_ready}, 2'b11);
    end
    step(1);
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_err, cfg_ready} !== 2'b00) begin
      errors++; $display("FAIL zs_k3: got %b want %b", {cfg_err, cfg_ready}, 2'b00);
    end
    step(1);
    checks++;
    if ({cfg_err, cfg_ready, running} !== 3'b111) begin
      errors++; $display("FAIL zs_err_k4: got %b want %b", {cfg_err, cfg_ready, running}, 3'b111);
    end
    step(763);
    checks++;
    if ({lrclk, frame_start} !== 2'b10) begin
      errors++; $display("FAIL z_frame_k767: got %b want %b", {lrclk, frame_start}, 2'b10);
    end
    step(1);
    checks++;
    if ({lrclk, frame_start} !== 2'b01) begin
      errors++; $display("FAIL z_frame_k768: got %b want %b", {lrclk, frame_start}, 2'b01);
    end
  endtask

  task automatic test_reconfig;
    cfg_valid = 1'b1; cfg_lrclk_div = 16'd256; cfg_sclk_div = 8'd4;
    step(1);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL rc_ready_k1: got %b want 0", cfg_ready); end
    step(766);
    checks++;
    if ({running, lrclk, cfg_done} !== 3'b110) begin
      errors++; $display("FAIL rc_drain_k767: got %b want %b", {running, lrclk, cfg_done}, 3'b110);
    end
    step(1);
    checks++;
    if ({running, lrclk, sclk, frame_start, cfg_ready} !== 5'b00000) begin
      errors++;
      $display("FAIL rc_quiet_k768: got %b want %b",
               {running, lrclk, sclk, frame_start, cfg_ready}, 5'b00000);
    end
    step(15);
    checks++;
    if ({running, lrclk, sclk, cfg_done} !== 4'b0000) begin
      errors++; $display("FAIL rc_quiet_k783: got %b want %b", {running, lrclk, sclk, cfg_done}, 4'b0000);
    end
    step(1);
    checks++;
    if ({cfg_done, frame_start, running, cfg_ready} !== 4'b1111) begin
      errors++;
      $display("FAIL rc_restart_k784: got %b want %b", {cfg_done, frame_start, running, cfg_ready}, 4'b1111);
    end
    step(3);
    checks++;
    if (sclk !== 1'b0) begin errors++; $display("FAIL rc_sclk_j3: got %b want 0", sclk); end
    step(1);
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL rc_sclk_j4: got %b want 1", sclk); end
    step(4);
    checks++;
    if (sclk !== 1'b0) begin errors++; $display("FAIL rc_sclk_j8: got %b want 0", sclk); end
    step(247);
    checks++;
    if (lrclk !== 1'b0) begin errors++; $display("FAIL rc_lrclk_j255: got %b want 0", lrclk); end
    step(1);
    checks++;
    if (lrclk !== 1'b1) begin errors++; $display("FAIL rc_lrclk_j256: got %b want 1", lrclk); end
    step(255);
    checks++;
    if ({lrclk, frame_start} !== 2'b10) begin
      errors++; $display("FAIL rc_frame_j511: got %b want %b", {lrclk, frame_start}, 2'b10);
    end
    step(1);
    checks++;
    if ({lrclk, frame_start} !== 2'b01) begin
      errors++; $display("FAIL rc_frame_j512: got %b want %b", {lrclk, frame_start}, 2'b01);
    end
  endtask

  task automatic test_disable;
    enable = 1'b0;
    step(1);
    checks++;
    if ({running, cfg_ready} !== 2'b10) begin
      errors++; $display("FAIL dis_drain_j1: got %b want %b", {running, cfg_ready}, 2'b10);
    end
    step(510);
    checks++;
    if ({running, lrclk} !== 2'b11) begin
      errors++; $display("FAIL dis_j511: got %b want %b", {running, lrclk}, 2'b11);
    end
    step(1);
    checks++;
    if ({running, lrclk, sclk, cfg_ready, frame_start} !== 5'b00010) begin
      errors++;
      $display("FAIL dis_idle_j512: got %b want %b",
               {running, lrclk, sclk, cfg_ready, frame_start}, 5'b00010);
    end
    step(5);
    checks++;
    if ({running, lrclk, sclk, cfg_ready, cfg_done} !== 5'b00010) begin
      errors++;
      $display("FAIL dis_idle_j517: got %b want %b",
               {running, lrclk, sclk, cfg_ready, cfg_done}, 5'b00010);
    end
    enable = 1'b1;
    step(1);
    checks++;
    if ({running, frame_start} !== 2'b11) begin
      errors++; $display("FAIL dis_restart: got %b want %b", {running, frame_start}, 2'b11);
    end
    step(255);
    checks++;
    if (lrclk !== 1'b0) begin errors++; $display("FAIL dis_lrclk_255: got %b want 0", lrclk); end
    step(1);
    checks++;
    if (lrclk !== 1'b1) begin errors++; $display("FAIL dis_lrclk_256: got %b want 1", lrclk); end
    step(256);
    checks++;
    if (frame_start !== 1'b1) begin errors++; $display("FAIL dis_frame_512: got %b want 1", frame_start); end
  endtask

  task automatic test_rst_in_drain;
    cfg_valid = 1'b1; cfg_lrclk_div = 16'd256; cfg_sclk_div = 8'd4;
    step(1);
    cfg_valid = 1'b0;
    step(99);
    checks++;
    if ({running, cfg_ready} !== 2'b10) begin
      errors++; $display("FAIL rd_drain_k100: got %b want %b", {running, cfg_ready}, 2'b10);
    end
    rst = 1'b1; enable = 1'b0;
    step(1);
    checks++;
    if ({lrclk, sclk, running, frame_start, cfg_err, cfg_done, cfg_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL rd_reset: got %b want %b",
               {lrclk, sclk, running, frame_start, cfg_err, cfg_done, cfg_ready}, 7'b0000001);
    end
    rst = 1'b0;
    step(20);
    checks++;
    if ({cfg_done, running, lrclk, cfg_ready} !== 4'b0001) begin
      errors++; $display("FAIL rd_idle: got %b want %b", {cfg_done, running, lrclk, cfg_ready}, 4'b0001);
    end
    enable = 1'b1;
    step(1);
    checks++;
    if ({running, frame_start} !== 2'b11) begin
      errors++; $display("FAIL rd_restart: got %b want %b", {running, frame_start}, 2'b11);
    end
    step(8);
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL rd_sclk_k8: got %b want 1", sclk); end
    step(375);
    checks++;
    if (lrclk !== 1'b0) begin errors++; $display("FAIL rd_lrclk_k383: got %b want 0", lrclk); end
    step(1);
    checks++;
    if (lrclk !== 1'b1) begin errors++; $display("FAIL rd_lrclk_k384: got %b want 1", lrclk); end
  endtask

  task automatic test_idle_reconfig;
    rst = 1'b1; enable = 1'b0;
    step(1);
    rst = 1'b0;
    step(1);
    cfg_valid = 1'b1; cfg_lrclk_div = 16'd128; cfg_sclk_div = 8'd8;
    step(1);
    cfg_valid = 1'b0;
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ir_ready_t1: got %b want 0", cfg_ready); end
    step(16);
    checks++;
    if ({cfg_done, cfg_ready, running, lrclk} !== 4'b0000) begin
      errors++; $display("FAIL ir_t17: got %b want %b", {cfg_done, cfg_ready, running, lrclk}, 4'b0000);
    end
    step(1);
    checks++;
    if ({cfg_done, cfg_ready, cfg_err, running} !== 4'b1100) begin
      errors++; $display("FAIL ir_done_t18: got %b want %b", {cfg_done, cfg_ready, cfg_err, running}, 4'b1100);
    end
    step(1);
    enable = 1'b1;
    step(1);
    checks++;
    if ({running, frame_start} !== 2'b11) begin
      errors++; $display("FAIL ir_restart: got %b want %b", {running, frame_start}, 2'b11);
    end
    step(127);
    checks++;
    if (lrclk !== 1'b0) begin errors++; $display("FAIL ir_lrclk_127: got %b want 0", lrclk); end
    step(1);
    checks++;
    if (lrclk !== 1'b1) begin errors++; $display("FAIL ir_lrclk_128: got %b want 1", lrclk); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
    cfg_lrclk_div = '0; cfg_sclk_div = '0;
    test_reset();
    test_default_run();
    test_reject_range();
    test_reject_zero();
    test_reconfig();
    test_disable();
    test_rst_in_drain();
    test_idle_reconfig();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
